jtdd_gfx_arb: RTL and testbench
===============================

Name: jtdd_gfx_arb

Overview:
Shares one graphics-ROM (SDRAM) read port between three tile fetchers: char layer (slot 0), scroll layer (slot 1) and object layer (slot 2).
- Each slot keeps a one-entry cache of its last fetched byte. It signals ok while its requested address matches that cache.
- Misses are served one at a time, in round-robin order, through a req/ack/rdy handshake to the SDRAM controller.
- Sits between the jtdd video layers and the SDRAM controller. Each layer sees a plain rom_addr/rom_data/rom_ok interface.

Parameters:
AW0, 16, char ROM address width
AW1, 17, scroll ROM address width
AW2, 18, object ROM address width
OFS1, 22'h010000, SDRAM base of scroll ROM
OFS2, 22'h030000, SDRAM base of object ROM (char base is 0)
SAW, 22, SDRAM address width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
char_addr  in  AW0  slot 0 address
char_cs  in  1  slot 0 request enable
char_data  out  8  slot 0 data
char_ok  out  1  slot 0 data valid for current address
scr_addr  in  AW1  slot 1 address
scr_cs  in  1  slot 1 request enable
scr_data  out  8  slot 1 data
scr_ok  out  1  slot 1 data valid
obj_addr  in  AW2  slot 2 address
obj_cs  in  1  slot 2 request enable
obj_data  out  8  slot 2 data
obj_ok  out  1  slot 2 data valid
sdram_addr  out  SAW  fetch address
sdram_req  out  1  fetch request
sdram_ack  in  1  controller accepted request
data_rdy  in  1  fetch data valid
sdram_din  in  8  fetch data

Behaviour:
- Reset (rst_n low, async): all cache valid bits=0, cached addresses and data=0, *_data=0, *_ok=0, sdram_req=0, sdram_addr=0, state=IDLE, rr pointer=0 (slot 0 highest). Reset mid-fetch abandons the fetch; a later data_rdy while IDLE is ignored.
- Per slot i:
  - hit_i = cs_i & valid_i & (cache_addr_i == addr_i).
  - ok_i = hit_i, combinational from flops plus inputs.
  - data_i = cache_data_i, always driven from the cache.
  - miss_i = cs_i & ~hit_i.
  - cs_i low: ok_i=0, cache retained.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE, any miss:
  - Grant the first missing slot at or after the rr pointer (order 0,1,2, wrapping).
  - Latch gnt index and gnt_addr=addr_gnt.
  - Next cycle: sdram_addr = zero-extended addr + OFS_gnt (mod 2^SAW) and sdram_req=1.
  - Move to WAIT_ACK. rr pointer = gnt+1 (2 wraps to 0).
- WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack, clear sdram_req next cycle and go to WAIT_DATA.
- WAIT_DATA: on data_rdy, write sdram_din and gnt_addr into slot gnt, set valid_gnt=1, return to IDLE.
- sdram_ack and data_rdy high in the same cycle while in WAIT_ACK: treat as complete. Write the cache and go directly to IDLE.
- Address change during a fetch: the fetch completes and the cache stores the latched gnt_addr. ok stays low if the address no longer matches, and the slot misses again on the next IDLE pass.
- Minimum miss latency: addr presented at cycle 0 → req rises cycle 1 → ack at cycle 1 → rdy at cycle N → ok high at cycle N+1.
- data_rdy outside WAIT_ACK/WAIT_DATA: ignored.
- Only one fetch is outstanding. No timeout.

Decomposition:
- Package jtdd_gfx_pkg:
  - state enum (IDLE, WAIT_ACK, WAIT_DATA);
  - slot index constants SLOT_CHAR=0, SLOT_SCR=1, SLOT_OBJ=2;
  - NSLOTS=3.
- Sub-module jtdd_gfx_slot (parameter AW), instantiated three times:
  - holds valid, cache_addr and cache_data;
  - produces hit/miss/ok/data;
  - write port driven by the arbiter.

Test Plan:
1. After reset, char_cs=1, char_addr=16'h1234; bench acks in the cycle after sdram_req rises and returns rdy 3 cycles later with 8'hA5 → sdram_addr=22'h001234, then char_ok=1, char_data=8'hA5. Holding the address keeps ok high with no further sdram_req.
2. All three slots miss in the same cycle (scr_addr=17'h00010, obj_addr=18'h00020) → grants in order char, scr, obj. Second sdram_addr=22'h010010, third=22'h030020.
3. After test 1, change char_addr to 16'h1235 → char_ok falls in the same cycle and a new fetch is issued. Returning to 16'h1234 later misses again (single-entry cache).
4. Change scr_addr while its fetch is in WAIT_DATA → cache stores the old address, scr_ok stays 0, and a second fetch for the new address follows.
5. sdram_ack and data_rdy pulsed together with data 8'h3C → slot updated, FSM back in IDLE the next cycle, no stuck req.
6. Pull rst_n low in WAIT_DATA, release, then pulse data_rdy → no cache is written, all ok=0, and sdram_req=0 until a new miss.

Source files
------------

// File: rtl/jtdd_gfx_pkg.sv
// Shared types and constants for the jtdd graphics-ROM arbiter.
package jtdd_gfx_pkg;

    localparam int NSLOTS = 3;

    localparam logic [1:0] SLOT_CHAR = 2'd0;
    localparam logic [1:0] SLOT_SCR  = 2'd1;
    localparam logic [1:0] SLOT_OBJ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    // First missing slot at or after ptr, scanning 0,1,2 with wrap-around.
    function automatic logic [1:0] rr_pick(input logic [NSLOTS-1:0] miss, input logic [1:0] ptr);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < NSLOTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NSLOTS) idx = idx - NSLOTS;
            if (!found && miss[idx]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtdd_gfx_slot.sv
// One-entry byte cache for a single tile fetcher; filled by the arbiter.
module jtdd_gfx_slot #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          ok,
    output logic          miss,
    output logic [7:0]    data
);

    logic          valid;
    logic [AW-1:0] cache_addr;
    logic [7:0]    cache_data;
    logic          hit;

    // NOTE: the cache is three flops, not a RAM, so resetting it is cheap and
    // guarantees a post-reset data_rdy can never surface as a stale hit.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
        end else if (we) begin
            valid      <= 1'b1;
            cache_addr <= wr_addr;
            cache_data <= wr_data;
        end
    end

    assign hit  = cs & valid & (cache_addr == addr);
    assign ok   = hit;
    assign miss = cs & ~hit;
    assign data = cache_data;

endmodule

// File: rtl/jtdd_gfx_arb.sv
// Round-robin arbiter sharing one SDRAM read port among the char, scroll and
// object tile fetchers, each fronted by a one-entry cache.
module jtdd_gfx_arb
    import jtdd_gfx_pkg::*;
#(
    parameter int             AW0  = 16,
    parameter int             AW1  = 17,
    parameter int             AW2  = 18,
    parameter int             SAW  = 22,
    parameter logic [SAW-1:0] OFS1 = 22'h010000,
    parameter logic [SAW-1:0] OFS2 = 22'h030000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW0-1:0] char_addr,
    input  logic           char_cs,
    output logic [7:0]     char_data,
    output logic           char_ok,
    input  logic [AW1-1:0] scr_addr,
    input  logic           scr_cs,
    output logic [7:0]     scr_data,
    output logic           scr_ok,
    input  logic [AW2-1:0] obj_addr,
    input  logic           obj_cs,
    output logic [7:0]     obj_data,
    output logic           obj_ok,
    output logic [SAW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [7:0]     sdram_din
);

    localparam int GAW01 = (AW0 > AW1) ? AW0 : AW1;
    localparam int GAW   = (GAW01 > AW2) ? GAW01 : AW2;

    state_t            state, state_nxt;
    logic [1:0]        gnt, gnt_nxt;
    logic [1:0]        rr, rr_nxt;
    logic [1:0]        sel;
    logic [GAW-1:0]    gnt_addr, gnt_addr_nxt;
    logic [SAW-1:0]    sdram_addr_nxt;
    logic              sdram_req_nxt;
    logic              fill;
    logic [NSLOTS-1:0] miss;
    logic [NSLOTS-1:0] we;

    jtdd_gfx_slot #(.AW(AW0)) u_char (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (char_addr),
        .cs      (char_cs),
        .we      (we[SLOT_CHAR]),
        .wr_addr (gnt_addr[AW0-1:0]),
        .wr_data (sdram_din),
        .ok      (char_ok),
        .miss    (miss[SLOT_CHAR]),
        .data    (char_data)
    );

    jtdd_gfx_slot #(.AW(AW1)) u_scr (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (scr_addr),
        .cs      (scr_cs),
        .we      (we[SLOT_SCR]),
        .wr_addr (gnt_addr[AW1-1:0]),
        .wr_data (sdram_din),
        .ok      (scr_ok),
        .miss    (miss[SLOT_SCR]),
        .data    (scr_data)
    );

    jtdd_gfx_slot #(.AW(AW2)) u_obj (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (obj_addr),
        .cs      (obj_cs),
        .we      (we[SLOT_OBJ]),
        .wr_addr (gnt_addr[AW2-1:0]),
        .wr_data (sdram_din),
        .ok      (obj_ok),
        .miss    (miss[SLOT_OBJ]),
        .data    (obj_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= SLOT_CHAR;
            rr         <= SLOT_CHAR;
            gnt_addr   <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            rr         <= rr_nxt;
            gnt_addr   <= gnt_addr_nxt;
            sdram_addr <= sdram_addr_nxt;
            sdram_req  <= sdram_req_nxt;
        end
    end

    // NOTE: every comb output gets a hold/default value first so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        rr_nxt         = rr;
        gnt_addr_nxt   = gnt_addr;
        sdram_addr_nxt = sdram_addr;
        sdram_req_nxt  = sdram_req;
        fill           = 1'b0;
        sel            = rr_pick(miss, rr);

        case (state)
            IDLE: begin
                if (|miss) begin
                    gnt_nxt       = sel;
                    sdram_req_nxt = 1'b1;
                    state_nxt     = WAIT_ACK;
                    rr_nxt        = (sel == SLOT_OBJ) ? SLOT_CHAR : sel + 2'd1;
                    case (sel)
                        SLOT_SCR: begin
                            gnt_addr_nxt   = GAW'(scr_addr);
                            sdram_addr_nxt = SAW'(scr_addr) + OFS1;
                        end
                        SLOT_OBJ: begin
                            gnt_addr_nxt   = GAW'(obj_addr);
                            sdram_addr_nxt = SAW'(obj_addr) + OFS2;
                        end
                        default: begin
                            gnt_addr_nxt   = GAW'(char_addr);
                            sdram_addr_nxt = SAW'(char_addr);
                        end
                    endcase
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    sdram_req_nxt = 1'b0;
                    // A controller may return data in the same cycle it accepts.
                    if (data_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            we[i] = fill && (gnt == 2'(i));
        end
    end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Directed bench for jtdd_gfx_arb: fetch addresses are scoreboarded by a
// monitor on each sdram_req rise; cache results are checked after each fill.
module tb_jtdd_gfx_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] char_addr = '0;
    logic        char_cs = 1'b0;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr = '0;
    logic        scr_cs = 1'b0;
    logic [7:0]  scr_data;
    logic        scr_ok;
    logic [17:0] obj_addr = '0;
    logic        obj_cs = 1'b0;
    logic [7:0]  obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [7:0]  sdram_din = '0;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] exp_addr;
    logic        req_q = 1'b0;

    jtdd_gfx_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_addr  (char_addr),
        .char_cs    (char_cs),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_cs     (scr_cs),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_addr   (obj_addr),
        .obj_cs     (obj_cs),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each new fetch request must match the next expected address.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_q = 1'b0;
        end else begin
            if (sdram_req && !req_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got addr %0h expected no request at %0t", sdram_addr, $time);
                end else begin
                    exp_addr = exp_q.pop_front();
                    check("fetch_addr", sdram_addr, exp_addr);
                end
            end
            req_q = sdram_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req_seen"}, sdram_req, 1);
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic pulse_rdy(input logic [7:0] d);
        sdram_din = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input string name, input logic [7:0] d, input int gap);
        wait_req(name);
        pulse_ack();
        repeat (gap) tick();
        pulse_rdy(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_ok", {char_ok, scr_ok, obj_ok}, 0);
        check("rst_data", {char_data, scr_data, obj_data}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick();
        do_reset();

        // 1: single char miss, ack next cycle, rdy three cycles after ack
        exp_q.push_back(22'h001234);
        char_addr = 16'h1234;
        char_cs   = 1'b1;
        #1;
        check("t1_miss_ok", char_ok, 0);
        serve("t1", 8'hA5, 2);
        check("t1_ok", char_ok, 1);
        check("t1_data", char_data, 8'hA5);
        repeat (5) tick();
        check("t1_hold_ok", char_ok, 1);
        check("t1_no_req", sdram_req, 0);

        // 3: address change misses immediately; single entry forgets 1234
        exp_q.push_back(22'h001235);
        char_addr = 16'h1235;
        #1;
        check("t3_ok_fall", char_ok, 0);
        serve("t3a", 8'h5A, 0);
        check("t3a_ok", char_ok, 1);
        check("t3a_data", char_data, 8'h5A);
        exp_q.push_back(22'h001234);
        char_addr = 16'h1234;
        #1;
        check("t3_remiss", char_ok, 0);
        serve("t3b", 8'hA5, 1);
        check("t3b_ok", char_ok, 1);
        check("t3b_data", char_data, 8'hA5);

        char_cs = 1'b0;
        do_reset();

        // 2: three simultaneous misses, granted in slot order with offsets
        exp_q.push_back(22'h000040);
        exp_q.push_back(22'h010010);
        exp_q.push_back(22'h030020);
        char_addr = 16'h0040;
        scr_addr  = 17'h00010;
        obj_addr  = 18'h00020;
        char_cs   = 1'b1;
        scr_cs    = 1'b1;
        obj_cs    = 1'b1;
        serve("t2_char", 8'h11, 0);
        check("t2_char_ok", char_ok, 1);
        check("t2_scr_pending", scr_ok, 0);
        serve("t2_scr", 8'h22, 1);
        check("t2_scr_ok", scr_ok, 1);
        check("t2_obj_pending", obj_ok, 0);
        serve("t2_obj", 8'h33, 2);
        check("t2_all_ok", {char_ok, scr_ok, obj_ok}, 3'b111);
        check("t2_all_data", {char_data, scr_data, obj_data}, 24'h112233);

        // 4: scr address moves while its fetch is in WAIT_DATA
        exp_q.push_back(22'h010100);
        scr_addr = 17'h00100;
        wait_req("t4a");
        pulse_ack();
        exp_q.push_back(22'h010200);
        scr_addr = 17'h00200;
        tick();
        pulse_rdy(8'h44);
        check("t4_stale_ok", scr_ok, 0);
        check("t4_stale_data", scr_data, 8'h44);
        serve("t4b", 8'h55, 1);
        check("t4b_ok", scr_ok, 1);
        check("t4b_data", scr_data, 8'h55);

        // 5: ack and rdy in the same cycle
        exp_q.push_back(22'h030030);
        obj_addr = 18'h00030;
        wait_req("t5");
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        sdram_din = 8'h3C;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("t5_ok", obj_ok, 1);
        check("t5_data", obj_data, 8'h3C);
        check("t5_req_low", sdram_req, 0);
        repeat (4) tick();
        check("t5_req_stays_low", sdram_req, 0);

        // 6: reset during WAIT_DATA, then a stray data_rdy
        exp_q.push_back(22'h000777);
        char_addr = 16'h0777;
        wait_req("t6");
        pulse_ack();
        rst_n   = 1'b0;
        char_cs = 1'b0;
        scr_cs  = 1'b0;
        obj_cs  = 1'b0;
        #1;
        check("t6_rst_req", sdram_req, 0);
        check("t6_rst_data", {char_data, scr_data, obj_data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_rdy(8'hEE);
        repeat (3) tick();
        check("t6_stray_req", sdram_req, 0);
        check("t6_stray_data", {char_data, scr_data, obj_data}, 0);
        check("t6_stray_ok", {char_ok, scr_ok, obj_ok}, 0);
        exp_q.push_back(22'h000777);
        char_cs = 1'b1;
        #1;
        check("t6_miss_ok", char_ok, 0);
        serve("t6b", 8'h77, 0);
        check("t6b_ok", char_ok, 1);
        check("t6b_data", char_data, 8'h77);

        repeat (3) tick();
        check("pending_fetches", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
